time_set_entry: RTL
===================

# time_set_entry

Interactive time-entry block for the digital clock: the inverse of the display-mode formatter. It takes single-cycle button pulses, lets the user edit four BCD digits (hour tens/ones, minute tens/ones) plus an AM/PM flag, validates each digit against 24-hour or 12-hour limits, and converts the result back to binary hour/minute. On commit it issues a one-cycle `load` pulse so the timekeeping counters can reload. It sits between the debounced/one-pulse button logic and the time counter, and its digit outputs drive the same 7-segment scan path.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins an edit session from IDLE.
- `mode12` in 1: 1 = 12-hour entry, 0 = 24-hour; sampled only on accepted `start`.
- `inc` in 1: one-cycle pulse; increments the selected field.
- `next` in 1: one-cycle pulse; advances to the next field.
- `cancel` in 1: one-cycle pulse; aborts the session without loading.
- `cur_hour` in 7: current binary hour, 0–23; values ≥24 are treated as 0.
- `cur_minute` in 7: current binary minute, 0–59; values ≥60 are treated as 0.
- `dig0`..`dig3` out 5 each: BCD minute ones, minute tens, hour ones, hour tens; value range 0–9.
- `pm` out 1: PM flag; meaningful only in 12-hour sessions, otherwise 0.
- `blink_sel` out 4: one-hot field being edited. Bit3 = H10, bit2 = H1, bit1 = M10, bit0 = M1. All four bits are set in EDIT_PM. 0 otherwise.
- `busy` out 1: high in any state other than IDLE.
- `load` out 1: one-cycle commit pulse.
- `set_hour`, `set_minute`, `set_second` out 7 each: binary time. Valid while `load` is high; held afterwards. `set_second` is always 0.

## Operation
- States: IDLE, EDIT_H10, EDIT_H1, EDIT_M10, EDIT_M1, EDIT_PM, COMMIT.
- Reset values: state IDLE, all digits 0, `pm` 0, `busy` 0, `load` 0, `blink_sel` 0, `set_*` 0, `mode_q` 0.
- **Start:** `start` in IDLE
  - Latches `mode_q` from `mode12`.
  - Preloads the digits from `cur_hour`/`cur_minute` and goes to EDIT_H10.
  - 24-hour preload: hour digits are `cur_hour` split into tens and ones.
  - 12-hour preload:
    - hour 0 → 12, pm = 0
    - hour 1–11 → unchanged, pm = 0
    - hour 12 → 12, pm = 1
    - hour 13–23 → hour − 12, pm = 1
  - `start` is ignored while `busy`.
- **Input priority (edit states):** `cancel` > `next` > `inc`. Simultaneous pulses act on the highest-priority pulse only.
- **`inc` wrap rules:** increment; past the max, wrap to the min.
  - H10: 24h 0–2; 12h 0–1.
  - H1, 24h: 0–3 if H10 = 2, else 0–9.
  - H1, 12h: 0–2 if H10 = 1, else 1–9.
  - M10: 0–5.
  - M1: 0–9.
  - EDIT_PM: `inc` toggles `pm`.
- **Clamping on `next` from EDIT_H10:** if H1 is above the new max, H1 is set to the max. If H1 is below the min (12h, H10 = 0, H1 = 0), H1 is set to 1.
- **`next` sequence:**
  - H10 → H1 → M10 → M1.
  - From M1: to EDIT_PM when `mode_q` = 1, else to COMMIT.
  - EDIT_PM → COMMIT.
- **`cancel`:** from any edit state goes to IDLE. Digits keep their edited values, `load` is not asserted, `set_*` is unchanged.
- **COMMIT conversion:**
  - minute = 10·M10 + M1.
  - 24h: hour = 10·H10 + H1.
  - 12h: let h = 10·H10 + H1 (1–12).
    - AM: hour = 0 if h = 12, else h.
    - PM: hour = 12 if h = 12, else h + 12.
- Arithmetic is done in 7 bits. A committed result always satisfies hour ≤ 23 and minute ≤ 59.

## Timing
- All state and output registers update on the `clk` rising edge. Outputs are registered.
- `start` at cycle N: at N+1, state = EDIT_H10, `busy` = 1, digits are preloaded, `blink_sel` = 4'b1000.
- `inc` or `next` at cycle N: the change is visible at N+1.
- Final `next` at cycle N: COMMIT at N+1 with `load` = 1 and `set_*` valid; IDLE at N+2 with `load` = 0 and `busy` = 0.
- COMMIT lasts exactly one cycle and ignores all inputs.
- `rst` mid-session returns to IDLE immediately with no `load`, and all outputs go to their reset values.
- IDLE ignores `inc`, `next` and `cancel`. Digits hold their last values.

## Structure
- Shared package `time_set_pkg`:
  - state enum.
  - field-limit constants (`H10_MAX24` = 2, `H10_MAX12` = 1, `M10_MAX` = 5, `DIG_MAX` = 9).
  - 12h/24h conversion function, shared with the display formatter.
- One sub-module, `bcd_digit_wrap`: a single 4-bit digit register with `min`/`max` inputs and `inc`, `load`, `clamp` controls, instantiated four times.

## Test plan
- 24h preload and commit: `cur_hour` = 17, `cur_minute` = 42, `mode12` = 0; `start`, then 4× `next` → `dig3..0` = 1,7,4,2; `load` is a single pulse with `set_hour` = 17, `set_minute` = 42, `set_second` = 0.
- 24h H1 limit: with H10 = 2, 4× `inc` on H1 from 0 → 1,2,3,0. H10 = 1 → 2 with H1 = 9, then `next` → H1 clamped to 3.
- 12h midnight: `cur_hour` = 0 → display 1,2 with `pm` = 0; commit without edits → `set_hour` = 0. Toggle `pm` in EDIT_PM, then commit → `set_hour` = 12.
- 12h PM conversion: `cur_hour` = 21 → display 0,9 with `pm` = 1. Edit H1 `inc` → wraps 9 → 1, commit → `set_hour` = 13.
- Priority and abort: `cancel` and `next` in the same cycle in EDIT_M10 → IDLE, no `load`. `start` while `busy` is ignored.
- Reset mid-session: assert `rst` in EDIT_M1 → `busy` = 0, digits 0, no `load` ever observed.

Source files
------------

// File: rtl/time_set_pkg.sv
// Shared types, field limits and 12h/24h hour conversion helpers for the clock
// time-entry and display formatting paths.
package time_set_pkg;

    localparam int unsigned HOUR_W = 7;
    localparam int unsigned DIG_W  = 4;

    localparam logic [DIG_W-1:0] H10_MAX24 = 4'd2;
    localparam logic [DIG_W-1:0] H10_MAX12 = 4'd1;
    localparam logic [DIG_W-1:0] M10_MAX   = 4'd5;
    localparam logic [DIG_W-1:0] DIG_MAX   = 4'd9;
    localparam logic [DIG_W-1:0] H1_MAX20  = 4'd3;
    localparam logic [DIG_W-1:0] H1_MAX10  = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT_H10,
        ST_EDIT_H1,
        ST_EDIT_M10,
        ST_EDIT_M1,
        ST_EDIT_PM,
        ST_COMMIT
    } state_t;

    typedef struct packed {
        logic              pm;
        logic [HOUR_W-1:0] hour;
    } hour12_t;

    typedef struct packed {
        logic [DIG_W-1:0] tens;
        logic [DIG_W-1:0] ones;
    } bcd2_t;

    // 0..23 -> 1..12 plus PM flag
    function automatic hour12_t hour24_to_12(input logic [HOUR_W-1:0] h24);
        hour12_t r;
        if (h24 == 7'd0) begin
            r.pm   = 1'b0;
            r.hour = 7'd12;
        end else if (h24 < 7'd12) begin
            r.pm   = 1'b0;
            r.hour = h24;
        end else if (h24 == 7'd12) begin
            r.pm   = 1'b1;
            r.hour = 7'd12;
        end else begin
            r.pm   = 1'b1;
            r.hour = 7'(h24 - 7'd12);
        end
        return r;
    endfunction

    // 1..12 plus PM flag -> 0..23
    function automatic logic [HOUR_W-1:0] hour12_to_24(input logic [HOUR_W-1:0] h12,
                                                      input logic pm);
        logic [HOUR_W-1:0] r;
        if (pm) r = (h12 == 7'd12) ? 7'd12 : 7'(h12 + 7'd12);
        else    r = (h12 == 7'd12) ? 7'd0  : h12;
        return r;
    endfunction

    function automatic bcd2_t bcd_split(input logic [HOUR_W-1:0] v);
        bcd2_t r;
        r.tens = 4'(v / 7'd10);
        r.ones = 4'(v % 7'd10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_wrap.sv
// One BCD digit register: preload, wrap-around increment within [min,max],
// and clamp into [min,max].
module bcd_digit_wrap
    import time_set_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DIG_W-1:0] i_min,
    input  logic [DIG_W-1:0] i_max,
    input  logic             i_inc,
    input  logic             i_load,
    input  logic [DIG_W-1:0] i_load_val,
    input  logic             i_clamp,
    output logic [DIG_W-1:0] o_q
);

    logic [DIG_W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_inc) begin
            r_q <= (r_q >= i_max) ? i_min : 4'(r_q + 4'd1);
        end else if (i_clamp) begin
            if (r_q > i_max)      r_q <= i_max;
            else if (r_q < i_min) r_q <= i_min;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/time_set_entry.sv
// Button-driven time entry: edits BCD hour/minute digits (12h or 24h) and
// commits them as binary hour/minute with a one-cycle load pulse.
module time_set_entry
    import time_set_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_mode12,
    input  logic              i_inc,
    input  logic              i_next,
    input  logic              i_cancel,
    input  logic [HOUR_W-1:0] i_cur_hour,
    input  logic [HOUR_W-1:0] i_cur_minute,
    output logic [4:0]        o_dig0,
    output logic [4:0]        o_dig1,
    output logic [4:0]        o_dig2,
    output logic [4:0]        o_dig3,
    output logic              o_pm,
    output logic [3:0]        o_blink_sel,
    output logic              o_busy,
    output logic              o_load,
    output logic [HOUR_W-1:0] o_set_hour,
    output logic [HOUR_W-1:0] o_set_minute,
    output logic [HOUR_W-1:0] o_set_second
);

    state_t            r_state, w_next_state;
    logic              r_mode;
    logic              r_pm, w_pm_next;
    logic              r_busy, r_load;
    logic [3:0]        r_blink, w_blink_next;
    logic [HOUR_W-1:0] r_set_hour, r_set_minute;

    logic [3:0]        w_inc;
    logic              w_preload, w_clamp_h1;
    logic [DIG_W-1:0]  w_m1, w_m10, w_h1, w_h10;
    logic [DIG_W-1:0]  w_h10_max, w_h1_min, w_h1_max;

    logic [HOUR_W-1:0] w_hour_in, w_min_in, w_hour_raw, w_hour_bin, w_min_bin;
    hour12_t           w_h12;
    bcd2_t             w_hour_bcd, w_min_bcd;
    logic              w_pm_preload;

    // Preload values from the running clock, sanitised and optionally in 12h form
    always_comb begin
        w_hour_in    = (i_cur_hour   >= 7'd24) ? '0 : i_cur_hour;
        w_min_in     = (i_cur_minute >= 7'd60) ? '0 : i_cur_minute;
        w_h12        = hour24_to_12(w_hour_in);
        w_hour_bcd   = bcd_split(i_mode12 ? w_h12.hour : w_hour_in);
        w_min_bcd    = bcd_split(w_min_in);
        w_pm_preload = i_mode12 & w_h12.pm;
    end

    // H1 range depends on mode and the current H10 digit
    always_comb begin
        w_h10_max = r_mode ? H10_MAX12 : H10_MAX24;
        w_h1_min  = 4'd0;
        w_h1_max  = DIG_MAX;
        if (r_mode) begin
            if (w_h10 == 4'd1) w_h1_max = H1_MAX10;
            else               w_h1_min = 4'd1;
        end else if (w_h10 == 4'd2) begin
            w_h1_max = H1_MAX20;
        end
    end

    always_comb begin
        w_min_bin  = 7'(7'(w_m10) * 7'd10 + 7'(w_m1));
        w_hour_raw = 7'(7'(w_h10) * 7'd10 + 7'(w_h1));
        w_hour_bin = r_mode ? hour12_to_24(w_hour_raw, r_pm) : w_hour_raw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next state and per-digit controls; cancel beats next beats inc
    always_comb begin
        w_next_state = r_state;
        w_inc        = 4'b0000;
        w_preload    = 1'b0;
        w_clamp_h1   = 1'b0;
        w_pm_next    = r_pm;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_EDIT_H10;
                    w_preload    = 1'b1;
                    w_pm_next    = w_pm_preload;
                end
            end
            ST_EDIT_H10: begin
                if (i_cancel) w_next_state = ST_IDLE;
                else if (i_next) begin
                    w_next_state = ST_EDIT_H1;
                    w_clamp_h1   = 1'b1;
                end else if (i_inc) w_inc[3] = 1'b1;
            end
            ST_EDIT_H1: begin
                if (i_cancel)    w_next_state = ST_IDLE;
                else if (i_next) w_next_state = ST_EDIT_M10;
                else if (i_inc)  w_inc[2] = 1'b1;
            end
            ST_EDIT_M10: begin
                if (i_cancel)    w_next_state = ST_IDLE;
                else if (i_next) w_next_state = ST_EDIT_M1;
                else if (i_inc)  w_inc[1] = 1'b1;
            end
            ST_EDIT_M1: begin
                if (i_cancel)    w_next_state = ST_IDLE;
                else if (i_next) w_next_state = r_mode ? ST_EDIT_PM : ST_COMMIT;
                else if (i_inc)  w_inc[0] = 1'b1;
            end
            ST_EDIT_PM: begin
                if (i_cancel)    w_next_state = ST_IDLE;
                else if (i_next) w_next_state = ST_COMMIT;
                else if (i_inc)  w_pm_next = ~r_pm;
            end
            ST_COMMIT: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase

        case (w_next_state)
            ST_EDIT_H10: w_blink_next = 4'b1000;
            ST_EDIT_H1:  w_blink_next = 4'b0100;
            ST_EDIT_M10: w_blink_next = 4'b0010;
            ST_EDIT_M1:  w_blink_next = 4'b0001;
            ST_EDIT_PM:  w_blink_next = 4'b1111;
            default:     w_blink_next = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= 1'b0;
            r_pm         <= 1'b0;
            r_busy       <= 1'b0;
            r_load       <= 1'b0;
            r_blink      <= 4'b0000;
            r_set_hour   <= '0;
            r_set_minute <= '0;
        end else begin
            r_pm    <= w_pm_next;
            r_busy  <= (w_next_state != ST_IDLE);
            r_load  <= (w_next_state == ST_COMMIT);
            r_blink <= w_blink_next;
            if (w_preload) r_mode <= i_mode12;
            if (w_next_state == ST_COMMIT) begin
                r_set_hour   <= w_hour_bin;
                r_set_minute <= w_min_bin;
            end
        end
    end

    bcd_digit_wrap u_h10 (
        .clk(clk), .rst(rst), .i_min(4'd0), .i_max(w_h10_max), .i_inc(w_inc[3]),
        .i_load(w_preload), .i_load_val(w_hour_bcd.tens), .i_clamp(1'b0), .o_q(w_h10)
    );

    bcd_digit_wrap u_h1 (
        .clk(clk), .rst(rst), .i_min(w_h1_min), .i_max(w_h1_max), .i_inc(w_inc[2]),
        .i_load(w_preload), .i_load_val(w_hour_bcd.ones), .i_clamp(w_clamp_h1), .o_q(w_h1)
    );

    bcd_digit_wrap u_m10 (
        .clk(clk), .rst(rst), .i_min(4'd0), .i_max(M10_MAX), .i_inc(w_inc[1]),
        .i_load(w_preload), .i_load_val(w_min_bcd.tens), .i_clamp(1'b0), .o_q(w_m10)
    );

    bcd_digit_wrap u_m1 (
        .clk(clk), .rst(rst), .i_min(4'd0), .i_max(DIG_MAX), .i_inc(w_inc[0]),
        .i_load(w_preload), .i_load_val(w_min_bcd.ones), .i_clamp(1'b0), .o_q(w_m1)
    );

    assign o_dig0       = {1'b0, w_m1};
    assign o_dig1       = {1'b0, w_m10};
    assign o_dig2       = {1'b0, w_h1};
    assign o_dig3       = {1'b0, w_h10};
    assign o_pm         = r_pm;
    assign o_blink_sel  = r_blink;
    assign o_busy       = r_busy;
    assign o_load       = r_load;
    assign o_set_hour   = r_set_hour;
    assign o_set_minute = r_set_minute;
    assign o_set_second = '0;

endmodule
